matrix_key_scan: RTL



---
 rtl/matrix_key_scan_pkg.sv | 29 ++
 rtl/matrix_key_scan_key_tick_gen.sv | 30 +++
 rtl/matrix_key_scan.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/matrix_key_scan_pkg.sv
// rtl/matrix_key_scan_pkg.sv - shared types and constants for the key matrix scanner
// Purpose: FSM state encoding, idle row/column patterns, key code width and
//          a row priority helper shared by the scanner files.
// Ports:   none (package).
package matrix_key_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DEBOUNCE     = 3'd1,
    ST_SCAN         = 3'd2,
    ST_REPORT       = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] COL_ALL  = 4'b0000;
  localparam int         KEY_W    = 4;

  // Index of the lowest-numbered row that is pulled low (rows are active low).
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_key_scan_key_tick_gen.sv
// rtl/matrix_key_scan_key_tick_gen.sv - free-running scan tick divider
// Purpose: divides CLK by SCAN_DIV and emits a one-cycle tick on the last count.
// Ports:   CLK  - system clock
//          RST  - asynchronous active-high reset
//          tick - one-CLK pulse every SCAN_DIV cycles
module key_tick_gen #(
  parameter int SCAN_DIV = 25000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_key_scan.sv
// rtl/matrix_key_scan.sv - 4x4 key matrix scanner with debounce and key encoding
// Purpose: detects a press on an active-low 4x4 matrix, debounces it, scans the
//          columns to locate the key, reports it once, then waits for release.
// Ports:   CLK         - system clock
//          RST         - asynchronous active-high reset
//          ROW[3:0]    - row inputs, active low, asynchronous to CLK
//          COL[3:0]    - column drives, active low (registered)
//          KEY_Value   - last reported key code, row*4 + col
//          Value_en    - one-CLK strobe, KEY_Value valid in the same cycle
//          KEY_Pressed - high from the report cycle until release is qualified
module matrix_key_scan
  import matrix_key_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       ROW,
  output logic [3:0]       COL,
  output logic [KEY_W-1:0] KEY_Value,
  output logic             Value_en,
  output logic             KEY_Pressed
);

  localparam int            DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_TICKS);

  logic             tick;
  logic [3:0]       row_meta_q;
  logic [3:0]       rs_q;
  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [DW-1:0]    rcnt_q, rcnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [KEY_W-1:0] key_value_q, key_value_d;
  logic             value_en_q, value_en_d;
  logic             key_pressed_q, key_pressed_d;

  key_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_meta_q <= ROW_IDLE;
      rs_q       <= ROW_IDLE;
    end else begin
      row_meta_q <= ROW;
      rs_q       <= row_meta_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    rcnt_d        = rcnt_q;
    col_idx_d     = col_idx_q;
    key_value_d   = key_value_q;
    key_pressed_d = key_pressed_q;

    case (state_q)
      ST_IDLE: begin
        if (tick && (rs_q != ROW_IDLE)) begin
          dcnt_d  = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (rs_q == ROW_IDLE) begin
            state_d = ST_IDLE;
          end else begin
            if (dcnt_q != DMAX) dcnt_d = dcnt_q + DW'(1);
            if (dcnt_d == DMAX) begin
              col_idx_d = 2'd0;
              state_d   = ST_SCAN;
            end
          end
        end
      end
      ST_SCAN: begin
        // COL was updated right after the previous tick, so rs has settled
        // through the synchronizer by the time this tick samples it.
        if (tick) begin
          if (rs_q != ROW_IDLE) begin
            key_value_d = {lowest_low_row(rs_q), col_idx_q};
            state_d     = ST_REPORT;
          end else if (col_idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      ST_REPORT: begin
        rcnt_d  = '0;
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (tick) begin
          if (rs_q != ROW_IDLE) begin
            rcnt_d = '0;
          end else begin
            if (rcnt_q != DMAX) rcnt_d = rcnt_q + DW'(1);
            if (rcnt_d == DMAX) begin
              key_pressed_d = 1'b0;
              state_d       = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so that Value_en, KEY_Value
    // and KEY_Pressed all change in the single cycle spent in REPORT.
    value_en_d = (state_d == ST_REPORT);
    if (state_d == ST_REPORT) key_pressed_d = 1'b1;
    col_d = (state_d == ST_SCAN) ? ~(4'b0001 << col_idx_d) : COL_ALL;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      dcnt_q        <= '0;
      rcnt_q        <= '0;
      col_idx_q     <= 2'd0;
      col_q         <= COL_ALL;
      key_value_q   <= '0;
      value_en_q    <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      rcnt_q        <= rcnt_d;
      col_idx_q     <= col_idx_d;
      col_q         <= col_d;
      key_value_q   <= key_value_d;
      value_en_q    <= value_en_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign COL         = col_q;
  assign KEY_Value   = key_value_q;
  assign Value_en    = value_en_q;
  assign KEY_Pressed = key_pressed_q;

endmodule
